// File: rtl/prob2_pipe_if.sv
// prob2_pipe_if -- stream bundle for the prob2_pipe lane pipeline.
//   Input side : in_valid / in_ready handshake with lane operands n1, n2, n3.
//   Output side: out_valid / out_ready handshake with lane results n11, n12, n13.
//   Status     : xfer_count, saturating count of completed output transfers.
// The slave modport is the pipeline's view; the master modport is the
// view of whatever drives the inputs and consumes the results.
interface prob2_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] n1;
    logic [WIDTH-1:0] n2;
    logic [WIDTH-1:0] n3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] n11;
    logic [WIDTH-1:0] n12;
    logic [WIDTH-1:0] n13;
    logic [CNT_W-1:0] xfer_count;

    modport slave (
        input  in_valid, n1, n2, n3, out_ready,
        output in_ready, out_valid, n11, n12, n13, xfer_count
    );

    modport master (
        output in_valid, n1, n2, n3, out_ready,
        input  in_ready, out_valid, n11, n12, n13, xfer_count
    );
endinterface

// File: rtl/prob2_pipe.sv
// prob2_pipe -- pipelined, multi-lane prob2 logic cone.
// Every bit-lane computes n11 = ~(n1&n2&~n3), n12 = n1|n2, n13 = n1?n3:n2.
// The results travel through STAGES registers under a valid/ready handshake
// whose backpressure ripples combinationally from out_ready to in_ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (clears valids, data and counter)
//   bus  - prob2_pipe_if.slave: in_valid/in_ready/n1/n2/n3 in,
//          out_valid/out_ready/n11/n12/n13 out, xfer_count status
module prob2_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    prob2_pipe_if.slave  bus
);
    localparam int DW   = 3 * WIDTH;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > 4 || WIDTH < 1) begin : g_param_check
        $error("prob2_pipe: STAGES must be 1..4 and WIDTH >= 1");
    end

    // First logic level: n6 = n1|n2, n7 = n2, n8 = n1&~n3, packed {n6,n7,n8}.
    function automatic logic [DW-1:0] level2(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] n6;
        logic [WIDTH-1:0] n7;
        logic [WIDTH-1:0] n8;
        n6 = a | b;
        n7 = b;
        n8 = a & ~c;
        return {n6, n7, n8};
    endfunction

    // Second logic level from packed {n6,n7,n8} to packed {n11,n12,n13}.
    function automatic logic [DW-1:0] level3(input logic [DW-1:0] l2);
        logic [WIDTH-1:0] n6;
        logic [WIDTH-1:0] n7;
        logic [WIDTH-1:0] n8;
        logic [WIDTH-1:0] n9;
        logic [WIDTH-1:0] n10;
        n6  = l2[DW-1 -: WIDTH];
        n7  = l2[2*WIDTH-1 -: WIDTH];
        n8  = l2[WIDTH-1:0];
        n9  = ~n6;
        n10 = ~(n6 | n7);
        return {~(n7 & n8), ~(n9 | n10), ~(n10 | n8)};
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [DW-1:0]     data_q [STAGES];
    logic [DW-1:0]     data_d [STAGES];
    logic [STAGES-1:0] adv_s;
    logic [DW-1:0]     stage0_s;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              xfer_s;

    // Stage-0 payload: the full cone for a single stage, else the level-2 nets.
    always_comb begin
        stage0_s = {DW{1'b0}};
        if (STAGES == 1) begin
            stage0_s = level3(level2(bus.n1, bus.n2, bus.n3));
        end else begin
            stage0_s = level2(bus.n1, bus.n2, bus.n3);
        end
    end

    // Backpressure: a stage may load if it is empty or its content leaves.
    // Walking from the output keeps bubbles collapsible in one cycle.
    always_comb begin
        logic take;
        take  = bus.out_ready;
        adv_s = {STAGES{1'b0}};
        for (int k = LAST; k >= 0; k--) begin
            take     = ~v_q[k] | take;
            adv_s[k] = take;
        end
    end

    // Stage next-state: loading stages take upstream valid/data, others hold.
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end
        if (adv_s[0]) begin
            v_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0] = stage0_s;
            end else begin
                data_d[0] = data_q[0];
            end
        end else begin
            v_d[0] = v_q[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv_s[k]) begin
                v_d[k] = v_q[k-1];
                // Data only moves with a valid token so bubbles leave it intact.
                if (v_q[k-1] && k == 1) begin
                    data_d[k] = level3(data_q[k-1]);
                end else if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end else begin
                    data_d[k] = data_q[k];
                end
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    assign xfer_s = v_q[LAST] & bus.out_ready;

    // Transfer counter: count completed output transfers, stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that also discards in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= {STAGES{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= {DW{1'b0}};
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.in_ready   = adv_s[0];
    assign bus.out_valid  = v_q[LAST];
    assign bus.n11        = data_q[LAST][DW-1 -: WIDTH];
    assign bus.n12        = data_q[LAST][2*WIDTH-1 -: WIDTH];
    assign bus.n13        = data_q[LAST][WIDTH-1:0];
    assign bus.xfer_count = cnt_q;
endmodule
